spi_crc_master: RTL

Parametrised SPI master that shifts one frame of `DATA_W` payload bits followed by a `CRC_W`-bit CRC, MSB first, full duplex. It supports all four SPI modes, selected per frame. It also checks the CRC of the received frame. Unlike the previous master, SCK is generated as a registered output in the `clk` domain, so no logic is clocked by SCK. The block sits between a host-side request/done handshake and the off-chip SPI pins.

---
 rtl/spi_pkg.sv | 20 ++
 rtl/spi_crc_master_if.sv | 28 ++
 rtl/spi_crc_serial.sv | 37 +++
 rtl/spi_crc_master.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI CRC master.
package spi_pkg;

  // Frame sequencer states
  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD,
    DONE
  } state_e;

  // Bit positions inside the 2-bit mode word {CPOL, CPHA}
  localparam int unsigned MODE_CPOL = 1;
  localparam int unsigned MODE_CPHA = 0;

  // SAE-J1850 polynomial (implicit top bit dropped) and seed
  localparam logic [7:0] CRC_POLY_DEF = 8'h1D;
  localparam logic [7:0] CRC_INIT_DEF = 8'hFF;

endpackage

// File: rtl/spi_crc_master_if.sv
// Host handshake plus SPI pins of the CRC master.
interface spi_crc_master_if #(
  parameter int unsigned DATA_W = 24
);

  logic              start;
  logic [1:0]        mode;
  logic [DATA_W-1:0] tx_data;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rx_data;
  logic              crc_err;
  logic              sck;
  logic              csn;
  logic              mo;
  logic              mi;

  modport master (
    input  start, mode, tx_data, mi,
    output busy, done, rx_data, crc_err, sck, csn, mo
  );

  modport slave (
    output start, mode, tx_data, mi,
    input  busy, done, rx_data, crc_err, sck, csn, mo
  );

endinterface

// File: rtl/spi_crc_serial.sv
// Bit-serial MSB-first CRC LFSR; clr reseeds, clr+en seeds and folds in one bit.
module spi_crc_serial
  import spi_pkg::*;
#(
  parameter int unsigned      CRC_W    = 8,
  parameter logic [CRC_W-1:0] CRC_POLY = CRC_W'(CRC_POLY_DEF),
  parameter logic [CRC_W-1:0] CRC_INIT = CRC_W'(CRC_INIT_DEF)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             en,
  input  logic             bit_in,
  output logic [CRC_W-1:0] crc
);

  logic [CRC_W-1:0] base_c;
  logic             fb_c;

  // Value the update starts from, and the feedback bit
  always_comb begin
    base_c = clr ? CRC_INIT : crc;
    fb_c   = base_c[CRC_W-1] ^ bit_in;
  end

  // LFSR register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      crc <= CRC_INIT;
    end else if (en) begin
      crc <= (base_c << 1) ^ (fb_c ? CRC_POLY : '0);
    end else if (clr) begin
      crc <= CRC_INIT;
    end
  end

endmodule

// File: rtl/spi_crc_master.sv
// SPI master: DATA_W payload bits then CRC_W CRC bits, MSB first, any mode; SCK is a clk-domain register.
module spi_crc_master
  import spi_pkg::*;
#(
  parameter int unsigned      DATA_W   = 24,
  parameter int unsigned      CRC_W    = 8,
  parameter logic [CRC_W-1:0] CRC_POLY = CRC_W'(CRC_POLY_DEF),
  parameter logic [CRC_W-1:0] CRC_INIT = CRC_W'(CRC_INIT_DEF),
  parameter int unsigned      CLK_DIV  = 4
) (
  input logic              clk,
  input logic              rstn,
  spi_crc_master_if.master bus
);

  localparam int unsigned N      = DATA_W + CRC_W;
  localparam int unsigned EDGES  = 2 * N;
  localparam int unsigned EDGE_W = $clog2(EDGES);
  localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W  = $clog2(N + 1);

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [EDGE_W-1:0]  edge_q, edge_d;
  logic               sck_q, sck_d;
  logic               csn_q, csn_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [1:0]         mode_q;
  logic               mo_q;
  logic [DATA_W-1:0]  tx_sr_q;
  logic [CRC_W-1:0]   crc_sr_q;
  logic [BIT_W-1:0]   tx_cnt_q;
  logic [BIT_W-1:0]   rx_cnt_q;
  logic [DATA_W-1:0]  rx_sr_q;
  logic [CRC_W-1:0]   rx_crc_q;
  logic [DATA_W-1:0]  rx_data_q;
  logic               crc_err_q;
  logic [CRC_W-1:0]   crc_tx;
  logic [CRC_W-1:0]   crc_rx;

  logic start_c, div_end_c, sck_edge_c, odd_edge_c, launch_c, sample_c;
  logic tx_pay_c, rx_pay_c, frame_end_c, tx_crc_en_c, tx_crc_bit_c;

  // Edge strobes: edge number edge_q+1 is odd when edge_q is even
  always_comb begin
    start_c      = (state_q == IDLE) && bus.start;
    div_end_c    = (div_q == DIV_W'(CLK_DIV - 1));
    sck_edge_c   = (state_q == SHIFT) && div_end_c;
    odd_edge_c   = ~edge_q[0];
    launch_c     = sck_edge_c && (odd_edge_c == mode_q[MODE_CPHA]) && (tx_cnt_q < BIT_W'(N));
    sample_c     = sck_edge_c && (odd_edge_c != mode_q[MODE_CPHA]);
    tx_pay_c     = (tx_cnt_q < BIT_W'(DATA_W));
    rx_pay_c     = (rx_cnt_q < BIT_W'(DATA_W));
    frame_end_c  = (state_q == HOLD) && div_end_c;
    tx_crc_en_c  = (start_c && !bus.mode[MODE_CPHA]) || (launch_c && tx_pay_c);
    tx_crc_bit_c = start_c ? bus.tx_data[DATA_W-1] : tx_sr_q[DATA_W-1];
  end

  // Sequencer state and registered control outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      div_q   <= '0;
      edge_q  <= '0;
      sck_q   <= 1'b0;
      csn_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      edge_q  <= edge_d;
      sck_q   <= sck_d;
      csn_q   <= csn_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next state: SCK divider and edge counter
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    edge_d  = edge_q;
    sck_d   = sck_q;
    csn_d   = csn_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SHIFT;
          div_d   = '0;
          edge_d  = '0;
          sck_d   = bus.mode[MODE_CPOL];
          csn_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end
      SHIFT: begin
        div_d = div_end_c ? '0 : div_q + DIV_W'(1);
        if (div_end_c) begin
          sck_d = ~sck_q;
          if (edge_q == EDGE_W'(EDGES - 1)) begin
            state_d = HOLD;
            edge_d  = '0;
          end else begin
            edge_d = edge_q + EDGE_W'(1);
          end
        end
      end
      HOLD: begin
        div_d = div_end_c ? '0 : div_q + DIV_W'(1);
        if (div_end_c) begin
          state_d = DONE;
          sck_d   = mode_q[MODE_CPOL];
          csn_d   = 1'b1;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Shift datapath: launch, sample, and result capture
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode_q    <= '0;
      mo_q      <= 1'b0;
      tx_sr_q   <= '0;
      crc_sr_q  <= '0;
      tx_cnt_q  <= '0;
      rx_cnt_q  <= '0;
      rx_sr_q   <= '0;
      rx_crc_q  <= '0;
      rx_data_q <= '0;
      crc_err_q <= 1'b0;
    end else begin
      if (start_c) begin
        mode_q   <= bus.mode;
        rx_cnt_q <= '0;
        if (!bus.mode[MODE_CPHA]) begin
          mo_q     <= bus.tx_data[DATA_W-1];
          tx_sr_q  <= bus.tx_data << 1;
          tx_cnt_q <= BIT_W'(1);
        end else begin
          mo_q     <= 1'b0;
          tx_sr_q  <= bus.tx_data;
          tx_cnt_q <= '0;
        end
      end
      if (launch_c) begin
        tx_cnt_q <= tx_cnt_q + BIT_W'(1);
        if (tx_pay_c) begin
          mo_q    <= tx_sr_q[DATA_W-1];
          tx_sr_q <= tx_sr_q << 1;
        end else if (tx_cnt_q == BIT_W'(DATA_W)) begin
          mo_q     <= crc_tx[CRC_W-1];
          crc_sr_q <= crc_tx << 1;
        end else begin
          mo_q     <= crc_sr_q[CRC_W-1];
          crc_sr_q <= crc_sr_q << 1;
        end
      end
      if (sample_c) begin
        rx_cnt_q <= rx_cnt_q + BIT_W'(1);
        if (rx_pay_c) begin
          rx_sr_q <= (rx_sr_q << 1) | DATA_W'(bus.mi);
        end else begin
          rx_crc_q <= (rx_crc_q << 1) | CRC_W'(bus.mi);
        end
      end
      if (frame_end_c) begin
        mo_q      <= 1'b0;
        rx_data_q <= rx_sr_q;
        crc_err_q <= (rx_crc_q != crc_rx);
      end
    end
  end

  spi_crc_serial #(
    .CRC_W    (CRC_W),
    .CRC_POLY (CRC_POLY),
    .CRC_INIT (CRC_INIT)
  ) u_crc_tx (
    .clk    (clk),
    .rstn   (rstn),
    .clr    (start_c),
    .en     (tx_crc_en_c),
    .bit_in (tx_crc_bit_c),
    .crc    (crc_tx)
  );

  spi_crc_serial #(
    .CRC_W    (CRC_W),
    .CRC_POLY (CRC_POLY),
    .CRC_INIT (CRC_INIT)
  ) u_crc_rx (
    .clk    (clk),
    .rstn   (rstn),
    .clr    (start_c),
    .en     (sample_c && rx_pay_c),
    .bit_in (bus.mi),
    .crc    (crc_rx)
  );

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rx_data = rx_data_q;
  assign bus.crc_err = crc_err_q;
  assign bus.sck     = sck_q;
  assign bus.csn     = csn_q;
  assign bus.mo      = mo_q;

endmodule
